// File: rtl/sha256_round_ctrl.sv
// ============================================================================
//  Module      : sha256_round_ctrl
//  Description : Block sequencer for a single-round SHA-256 compression
//                datapath; owns the chaining value H0..H7.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round_ctrl #(
    parameter int           ROUNDS = 64,
    parameter logic [255:0] IV     = 256'h6a09e667bb67ae85_3c6ef372a54ff53a_510e527f9b05688c_1f83d9ab5be0cd19
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        first_block,
    output logic                        ready,
    output logic                        sched_load,
    output logic                        select_value,
    output logic [255:0]                digest_in,
    output logic [$clog2(ROUNDS)-1:0]   round_idx,
    input  logic [255:0]                digest_core,
    output logic [255:0]                hash_out,
    output logic                        done
);

    localparam int CNT_W = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] c_last_round = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROUND  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [255:0]       r_h;
    logic [255:0]       w_h_nxt;
    logic [255:0]       w_h_sum;
    logic               r_done;
    logic               w_done_nxt;

    // Feed-forward: each 32-bit word adds independently, carries between words dropped.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word_add
            assign w_h_sum[gi*32 +: 32] = r_h[gi*32 +: 32] + digest_core[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_h_nxt      = r_h;
        w_done_nxt   = 1'b0;
        ready        = 1'b0;
        sched_load   = 1'b0;
        select_value = 1'b0;
        round_idx    = '0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_LOAD;
                    if (first_block) begin
                        w_h_nxt = IV;
                    end
                end
            end
            S_LOAD: begin
                select_value = 1'b1;
                sched_load   = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_ROUND;
            end
            S_ROUND: begin
                round_idx = r_cnt;
                if (r_cnt == c_last_round) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_UPDATE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_UPDATE: begin
                w_h_nxt     = w_h_sum;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_h     <= IV;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_h     <= w_h_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The datapath only samples digest_in while select_value is high.
    assign digest_in = r_h;
    assign hash_out  = r_h;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
// ============================================================================
//  Module      : tb_sha256_round_ctrl
//  Description : Self-checking bench for sha256_round_ctrl with a behavioural
//                datapath/schedule/K ROM and a whole-block reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_round_ctrl;

    typedef logic [0:15][31:0] blk_t;
    typedef logic [0:63][31:0] sched_t;

    localparam logic [255:0] c_iv      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_two_dig = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam blk_t c_abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam blk_t c_two_b1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam blk_t c_two_b2  = {{15{32'h0}}, 32'h000001c0};
    localparam sched_t c_k = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         first_block;
    logic         ready;
    logic         sched_load;
    logic         select_value;
    logic [255:0] digest_in;
    logic [5:0]   round_idx;
    logic [255:0] digest_core;
    logic [255:0] hash_out;
    logic         done;

    int     tests = 0;
    int     fails = 0;
    blk_t   tb_blk;
    sched_t dp_w;
    logic [255:0] dp_st = '0;

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .first_block  (first_block),
        .ready        (ready),
        .sched_load   (sched_load),
        .select_value (select_value),
        .digest_in    (digest_in),
        .round_idx    (round_idx),
        .digest_core  (digest_core),
        .hash_out     (hash_out),
        .done         (done)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic sched_t expand(input blk_t m);
        sched_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else        w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        end
        return w;
    endfunction

    // Environment model of the external single-round datapath.
    function automatic logic [255:0] one_round(input logic [255:0] s, input logic [31:0] kw);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bs1(e) + ((e & f) ^ (~e & g)) + kw;
        t2 = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Reference: full compression plus feed-forward of one block.
    function automatic logic [255:0] ref_block(input logic [255:0] h, input blk_t m);
        sched_t      w;
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        w = expand(m);
        for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + bs1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_k[t] + w[t];
            t2 = bs0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
        return r;
    endfunction

    assign digest_core = dp_st;

    always @(posedge clk) begin
        if (sched_load) dp_w <= expand(tb_blk);
        if (select_value) dp_st <= digest_in;
        else              dp_st <= one_round(dp_st, c_k[round_idx] + dp_w[round_idx]);
    end

    // Stimulus only: hashes one block and reports digest and start-to-done latency (-1 on timeout).
    task automatic run_block(input blk_t b, input logic first, output logic [255:0] dig, output int lat);
        int n;
        lat = -1;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        tb_blk      = b;
        first_block = first;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        first_block = 1'($urandom_range(1));
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        dig = hash_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; first_block = 1'b0; tb_blk = c_abc_blk;
        repeat (3) @(negedge clk);
        tests++; if (ready !== 1'b1)        begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests++; if (done !== 1'b0)         begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (hash_out !== c_iv)     begin fails++; $display("FAIL reset_hash: got %h want %h", hash_out, c_iv); end
        tests++; if (select_value !== 1'b0) begin fails++; $display("FAIL reset_select: got %b want 0", select_value); end
        tests++; if (sched_load !== 1'b0)   begin fails++; $display("FAIL reset_sched: got %b want 0", sched_load); end
        tests++; if (round_idx !== 6'd0)    begin fails++; $display("FAIL reset_round_idx: got %0d want 0", round_idx); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abc();
        logic [255:0] dig, exp;
        int lat;
        exp = ref_block(c_iv, c_abc_blk);
        run_block(c_abc_blk, 1'b1, dig, lat);
        tests++; if (lat != 66)        begin fails++; $display("FAIL abc_latency: got %0d want 66", lat); end
        tests++; if (dig !== c_abc_dig) begin fails++; $display("FAIL abc_digest: got %h want %h", dig, c_abc_dig); end
        tests++; if (dig !== exp)      begin fails++; $display("FAIL abc_model: got %h want %h", dig, exp); end
        @(negedge clk);
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL abc_done_width: got %b want 0", done); end
        tests++; if (hash_out !== exp) begin fails++; $display("FAIL abc_hold: got %h want %h", hash_out, exp); end
    endtask

    task automatic test_two_block();
        logic [255:0] d1, d2, e1, e2;
        int l1, l2;
        e1 = ref_block(c_iv, c_two_b1);
        e2 = ref_block(e1, c_two_b2);
        run_block(c_two_b1, 1'b1, d1, l1);
        run_block(c_two_b2, 1'b0, d2, l2);
        tests++; if (d1 !== e1)        begin fails++; $display("FAIL two_blk1: got %h want %h", d1, e1); end
        tests++; if (d2 !== c_two_dig) begin fails++; $display("FAIL two_digest: got %h want %h", d2, c_two_dig); end
        tests++; if (d2 !== e2)        begin fails++; $display("FAIL two_model: got %h want %h", d2, e2); end
        tests++; if (l2 != 66)         begin fails++; $display("FAIL two_latency: got %0d want 66", l2); end
    endtask

    task automatic test_sequencing();
        int sel_cnt, sl_cnt, bad_pos, bad_idx, bad_ready;
        int exp_idx;
        logic done_seen;
        sel_cnt = 0; sl_cnt = 0; bad_pos = 0; bad_idx = 0; bad_ready = 0; done_seen = 1'b0;
        tb_blk = c_abc_blk; first_block = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 66; k++) begin
            if (k > 0) @(negedge clk);
            exp_idx = (k >= 1 && k <= 64) ? k - 1 : 0;
            if (select_value) begin sel_cnt++; if (k != 0) bad_pos++; end
            if (sched_load)   begin sl_cnt++;  if (k != 0) bad_pos++; end
            if (round_idx !== 6'(exp_idx)) bad_idx++;
            if (k < 66 && ready !== 1'b0) bad_ready++;
            if (k == 66) done_seen = done;
        end
        tests++; if (sel_cnt != 1)       begin fails++; $display("FAIL seq_select_count: got %0d want 1", sel_cnt); end
        tests++; if (sl_cnt != 1)        begin fails++; $display("FAIL seq_sched_count: got %0d want 1", sl_cnt); end
        tests++; if (bad_pos != 0)       begin fails++; $display("FAIL seq_load_position: got %0d stray want 0", bad_pos); end
        tests++; if (bad_idx != 0)       begin fails++; $display("FAIL seq_round_idx: got %0d bad cycles want 0", bad_idx); end
        tests++; if (bad_ready != 0)     begin fails++; $display("FAIL seq_ready_busy: got %0d bad cycles want 0", bad_ready); end
        tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL seq_done_time: got %b want 1", done_seen); end
        tests++; if (hash_out !== c_abc_dig) begin fails++; $display("FAIL seq_digest: got %h want %h", hash_out, c_abc_dig); end
    endtask

    task automatic test_ignore_start();
        int n_done, done_k;
        n_done = 0; done_k = -1;
        tb_blk = c_abc_blk; first_block = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 75; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 11 || k == 65) begin
                start = 1'b1;
                first_block = 1'($urandom_range(1));
            end else begin
                start = 1'b0;
            end
            if (done) begin n_done++; done_k = k; end
        end
        tests++; if (n_done != 1)  begin fails++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
        tests++; if (done_k != 66) begin fails++; $display("FAIL ignore_done_time: got %0d want 66", done_k); end
        tests++; if (hash_out !== c_abc_dig) begin fails++; $display("FAIL ignore_digest: got %h want %h", hash_out, c_abc_dig); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] dig;
        int lat, n_done;
        n_done = 0;
        for (int i = 0; i < 16; i++) tb_blk[i] = $urandom;
        first_block = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (ready !== 1'b1)    begin fails++; $display("FAIL midrst_ready: got %b want 1", ready); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL midrst_done: got %b want 0", done); end
        tests++; if (hash_out !== c_iv) begin fails++; $display("FAIL midrst_hash: got %h want %h", hash_out, c_iv); end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        tests++; if (n_done != 0) begin fails++; $display("FAIL midrst_no_done: got %0d want 0", n_done); end
        run_block(c_abc_blk, 1'b0, dig, lat);
        tests++; if (dig !== c_abc_dig) begin fails++; $display("FAIL midrst_digest: got %h want %h", dig, c_abc_dig); end
        tests++; if (lat != 66)         begin fails++; $display("FAIL midrst_latency: got %0d want 66", lat); end
    endtask

    task automatic test_back_to_back();
        int n_done, k1, k2;
        logic [255:0] d1, d2;
        n_done = 0; k1 = -1; k2 = -1; d1 = '0; d2 = '0;
        tb_blk = c_abc_blk; first_block = 1'b1; start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (n_done == 1 && !done) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin k1 = k; d1 = hash_out; end
                else begin k2 = k; d2 = hash_out; end
            end
            if (n_done == 2) break;
        end
        start = 1'b0;
        tests++; if (n_done != 2)       begin fails++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        tests++; if (k1 != 66)          begin fails++; $display("FAIL b2b_first_time: got %0d want 66", k1); end
        tests++; if (k2 - k1 != 67)     begin fails++; $display("FAIL b2b_spacing: got %0d want 67", k2 - k1); end
        tests++; if (d1 !== c_abc_dig)  begin fails++; $display("FAIL b2b_first_digest: got %h want %h", d1, c_abc_dig); end
        tests++; if (d2 !== c_abc_dig)  begin fails++; $display("FAIL b2b_second_digest: got %h want %h", d2, c_abc_dig); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [255:0] h_exp, exp, dig;
        blk_t b;
        logic first;
        int lat;
        h_exp = c_iv;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) b[i] = $urandom;
            first = (r == 0) ? 1'b1 : 1'($urandom_range(1));
            if (first) h_exp = c_iv;
            exp = ref_block(h_exp, b);
            repeat ($urandom_range(3)) @(negedge clk);
            run_block(b, first, dig, lat);
            tests++; if (dig !== exp) begin fails++; $display("FAIL rand_digest[%0d] first=%b: got %h want %h", r, first, dig, exp); end
            tests++; if (lat != 66)   begin fails++; $display("FAIL rand_latency[%0d]: got %0d want 66", r, lat); end
            h_exp = exp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_sequencing();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
